// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: fetch handshake, field decode and
// DECODE/EXEC/MEM/WB sequencing with registered strobes.
module cu_multicycle #(
  parameter int RA_W        = 2,
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16,
  localparam int INST_W     = 4 + 2*RA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic              mem_ack,
  output logic [3:0]        opcode,
  output logic [RA_W-1:0]   rd,
  output logic [RA_W-1:0]   rs,
  output logic [DATA_W-1:0] immediate,
  output logic              alu_src,
  output logic              alu_en,
  output logic              flag_we,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              mem_err,
  output logic [CNT_W-1:0]  retired
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1
                        : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_MI  = 4'h2;
  localparam logic [3:0] OP_SUM = 4'h4;
  localparam logic [3:0] OP_SB  = 4'h5;
  localparam logic [3:0] OP_CM  = 4'h7;
  localparam logic [3:0] OP_ORI = 4'h9;
  localparam logic [3:0] OP_XRI = 4'hB;
  localparam logic [3:0] OP_SMI = 4'hC;
  localparam logic [3:0] OP_SBI = 4'hD;
  localparam logic [3:0] OP_ANI = 4'hE;
  localparam logic [3:0] OP_CMI = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]        r_opcode;
  logic [RA_W-1:0]   r_rd;
  logic [RA_W-1:0]   r_rs;
  logic [DATA_W-1:0] r_imm;
  logic              r_alu_src;
  logic              r_inst_ready;
  logic              r_alu_en;
  logic              r_flag_we;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_reg_write;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_retired;
  logic [WAIT_W-1:0] r_wait;

  logic [3:0]        w_op;
  logic [2*RA_W-1:0] w_f;
  logic [RA_W-1:0]   w_h;
  logic [RA_W-1:0]   w_l;
  logic              w_cls_mem;
  logic              w_cls_imm;
  logic [RA_W-1:0]   w_rd;
  logic [RA_W-1:0]   w_rs;
  logic [DATA_W-1:0] w_imm;
  logic              w_alu_src;
  logic              w_accept;
  logic              w_is_ld;
  logic              w_is_st;
  logic              w_is_cmp;
  logic              w_flag_op;
  logic              w_retire;
  logic              w_timeout;

  assign w_op = inst[INST_W-1 -: 4];
  assign w_f  = inst[2*RA_W-1:0];
  assign w_h  = inst[2*RA_W-1 -: RA_W];
  assign w_l  = inst[RA_W-1:0];

  assign w_cls_mem = (w_op == OP_LD) || (w_op == OP_ST)
                  || (w_op == OP_MI);
  assign w_cls_imm = (w_op == OP_SMI) || (w_op == OP_SBI)
                  || (w_op == OP_ANI) || (w_op == OP_CMI)
                  || (w_op == OP_ORI) || (w_op == OP_XRI);

  always_comb begin
    w_rd      = '0;
    w_rs      = '0;
    w_imm     = '0;
    w_alu_src = 1'b0;
    unique case (1'b1)
      w_cls_mem: begin
        w_imm     = DATA_W'($signed(w_f));
        w_alu_src = 1'b1;
      end
      w_cls_imm: begin
        w_rd      = w_h;
        w_imm     = DATA_W'($signed(w_l));
        w_alu_src = 1'b1;
      end
      default: begin
        w_rd = w_h;
        w_rs = w_l;
      end
    endcase
  end

  assign w_accept = (r_state == S_FETCH) && inst_valid;

  assign w_is_ld  = (r_opcode == OP_LD);
  assign w_is_st  = (r_opcode == OP_ST);
  assign w_is_cmp = (r_opcode == OP_CM) || (r_opcode == OP_CMI);
  assign w_flag_op = (r_opcode == OP_SUM) || (r_opcode == OP_SB)
                  || (r_opcode == OP_CM)  || (r_opcode == OP_SMI)
                  || (r_opcode == OP_SBI) || (r_opcode == OP_CMI);

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (inst_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = (w_is_ld || w_is_st) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        if (w_is_cmp) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        // ack takes priority over a timeout on the same cycle
        if (mem_ack) begin
          if (w_is_ld) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next    = S_FETCH;
          w_timeout = 1'b1;
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (r_state == S_MEM) ? r_wait + WAIT_W'(1) : '0;
    end
  end

  // strobes are registered from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode     <= '0;
      r_rd         <= '0;
      r_rs         <= '0;
      r_imm        <= '0;
      r_alu_src    <= 1'b0;
      r_inst_ready <= 1'b1;
      r_alu_en     <= 1'b0;
      r_flag_we    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_err    <= 1'b0;
      r_retired    <= '0;
    end else begin
      if (w_accept) begin
        r_opcode  <= w_op;
        r_rd      <= w_rd;
        r_rs      <= w_rs;
        r_imm     <= w_imm;
        r_alu_src <= w_alu_src;
      end
      r_inst_ready <= (w_next == S_FETCH);
      r_alu_en     <= (w_next == S_EXEC);
      r_flag_we    <= (w_next == S_EXEC) && w_flag_op;
      r_mem_read   <= (w_next == S_MEM) && w_is_ld;
      r_mem_write  <= (w_next == S_MEM) && w_is_st;
      r_reg_write  <= (w_next == S_WB);
      r_mem_err    <= w_timeout;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign inst_ready = r_inst_ready;
  assign opcode     = r_opcode;
  assign rd         = r_rd;
  assign rs         = r_rs;
  assign immediate  = r_imm;
  assign alu_src    = r_alu_src;
  assign alu_en     = r_alu_en;
  assign flag_we    = r_flag_we;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign reg_write  = r_reg_write;
  assign mem_err    = r_mem_err;
  assign retired    = r_retired;

endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: per-cycle expectations from a
// transaction-level model, checked by an independent monitor.
module tb_cu_multicycle;

  localparam int TMO = 16;

  logic       clk;
  logic       reset;
  logic [7:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic       mem_ack;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] immediate;
  logic       alu_src;
  logic       alu_en;
  logic       flag_we;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       mem_err;
  logic [15:0] retired;

  cu_multicycle dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .mem_ack    (mem_ack),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .immediate  (immediate),
    .alu_src    (alu_src),
    .alu_en     (alu_en),
    .flag_we    (flag_we),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_err    (mem_err),
    .retired    (retired)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       asrc;
  } fld_t;

  typedef struct packed {
    logic [5:0]  s;
    logic        err;
    logic [15:0] ret;
    fld_t        f;
  } obs_t;

  localparam logic [5:0] ST_IDLE = 6'b100000;
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_RD   = 6'b000100;
  localparam logic [5:0] ST_WR   = 6'b000010;
  localparam logic [5:0] ST_WB   = 6'b000001;

  obs_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;
  logic done = 1'b0;
  logic fin  = 1'b0;

  fld_t        m_f;
  logic [15:0] m_ret;
  logic        m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fld_t decode(input logic [7:0] i);
    fld_t f;
    logic [3:0] lo;
    lo = i[3:0];
    f.op = i[7:4];
    f.rd = 2'd0;
    f.rs = 2'd0;
    f.imm = 8'd0;
    f.asrc = 1'b1;
    if (f.op <= 4'h2) begin
      f.imm = {{4{lo[3]}}, lo};
    end else if (f.op inside {4'hC, 4'hD, 4'hE, 4'hF, 4'h9, 4'hB}) begin
      f.rd  = lo[3:2];
      f.imm = {{6{lo[1]}}, lo[1:0]};
    end else begin
      f.rd   = lo[3:2];
      f.rs   = lo[1:0];
      f.asrc = 1'b0;
    end
    return f;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic v, input logic [7:0] ins,
                     input logic ack, input logic rst,
                     input logic [5:0] s);
    obs_t e;
    @(posedge clk);
    #1;
    inst_valid = v;
    inst       = ins;
    mem_ack    = ack;
    reset      = rst;
    e = {s, m_err, m_ret, m_f};
    q.push_back(e);
    m_err = 1'b0;
  endtask

  task automatic run_inst(input logic [7:0] ins, input int gap,
                          input int ackd, input int abort_k);
    logic [3:0] op;
    logic       flg;
    int         last;
    logic       rst;
    op  = ins[7:4];
    flg = op inside {4'h4, 4'h5, 4'h7, 4'hC, 4'hD, 4'hF};
    for (int g = 0; g < gap; g++)
      cyc(1'b0, 8'($urandom), rbit(), 1'b0, ST_IDLE);
    cyc(1'b1, ins, rbit(), 1'b0, ST_IDLE);
    m_f = decode(ins);
    cyc(rbit(), 8'($urandom), rbit(), 1'b0, ST_NONE);
    if (op == 4'h0 || op == 4'h1) begin
      last = (ackd >= 0) ? ackd : TMO - 1;
      for (int k = 0; k <= last; k++) begin
        rst = (k == abort_k);
        cyc(rbit(), 8'($urandom), logic'(k == ackd), rst,
            (op == 4'h0) ? ST_RD : ST_WR);
        if (rst) begin
          m_f   = '0;
          m_ret = '0;
          m_err = 1'b0;
          return;
        end
      end
      if (ackd < 0) begin
        m_err = 1'b1;
      end else begin
        if (op == 4'h0)
          cyc(rbit(), 8'($urandom), rbit(), 1'b0, ST_WB);
        m_ret++;
      end
    end else begin
      cyc(rbit(), 8'($urandom), rbit(), 1'b0, {2'b01, flg, 3'b000});
      if (op != 4'h7 && op != 4'hF)
        cyc(rbit(), 8'($urandom), rbit(), 1'b0, ST_WB);
      m_ret++;
    end
  endtask

  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    n_cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {inst_ready, alu_en, flag_we, mem_read, mem_write,
           reg_write, mem_err, retired,
           opcode, rd, rs, immediate, alu_src};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle%0d rdy/alu/flg/mrd/mwr/rw got=%b exp=%b err got=%b exp=%b ret got=%0d exp=%0d op/rd/rs/imm/src got=%h/%0d/%0d/%h/%b exp=%h/%0d/%0d/%h/%b",
                 n_cyc, a.s, e.s, a.err, e.err, a.ret, e.ret,
                 a.f.op, a.f.rd, a.f.rs, a.f.imm, a.f.asrc,
                 e.f.op, e.f.rd, e.f.rs, e.f.imm, e.f.asrc);
      end
    end else if (done && !fin) begin
      fin = 1'b1;
      n_cmp++;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL drain pending got=%0d exp=0", q.size());
      end
    end
  end

  initial begin
    int ackd;
    int ab;
    reset      = 1'b1;
    inst_valid = 1'b0;
    inst       = 8'h00;
    mem_ack    = 1'b0;
    m_f        = '0;
    m_ret      = '0;
    m_err      = 1'b0;
    repeat (2) @(posedge clk);

    run_inst(8'h4B, 0, -1, -1);
    run_inst(8'h0C, 1, 2, -1);
    run_inst(8'hC6, 0, -1, -1);
    run_inst(8'h15, 0, -1, -1);
    run_inst(8'h79, 0, -1, -1);
    run_inst(8'h4B, 0, -1, -1);
    run_inst(8'h0C, 0, 6, 1);
    run_inst(8'h4B, 0, -1, -1);
    run_inst(8'h1A, 0, TMO - 1, -1);
    run_inst(8'h07, 2, 0, -1);
    run_inst(8'h2F, 0, -1, -1);

    for (int n = 0; n < 300; n++) begin
      ackd = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, TMO - 1);
      ab   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TMO - 1) : -1;
      run_inst(8'($urandom), $urandom_range(0, 2), ackd, ab);
    end

    cyc(1'b0, 8'h00, 1'b0, 1'b0, ST_IDLE);
    @(posedge clk);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_multicycle.md
Name: cu_multicycle

Overview:
- Parametrised, multi-cycle successor to the single-cycle control unit of the 8-bit processor.
- Accepts instructions over a valid/ready handshake from the fetch stage and decodes opcode, register fields and sign-extended immediate.
- Sequences each instruction through DECODE, EXEC, MEM and WB states, driving registered control strobes to the ALU, register file and data memory.
- Adds a memory-acknowledge handshake with timeout and a retired-instruction counter.

Parameters:
RA_W, 2, register-address field width; INST_W = 4 + 2*RA_W (8 at default)
DATA_W, 8, datapath width; immediate output width; must be >= 2*RA_W
MEM_TIMEOUT, 16, max cycles in MEM waiting for mem_ack before abort (>=1)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
inst  in  INST_W  instruction word
inst_valid  in  1  fetch offers inst
inst_ready  out  1  block accepts inst (high only in FETCH)
mem_ack  in  1  data memory completed current access
opcode  out  4  inst[INST_W-1:INST_W-4], held from capture
rd  out  RA_W  destination register
rs  out  RA_W  source register
immediate  out  DATA_W  sign-extended immediate
alu_src  out  1  1 = ALU B operand is immediate
alu_en  out  1  ALU strobe, EXEC only
flag_we  out  1  flag update strobe, EXEC only
mem_read  out  1  memory read, MEM only
mem_write  out  1  memory write, MEM only
reg_write  out  1  register-file write strobe, WB only
mem_err  out  1  one-cycle pulse on timeout
retired  out  CNT_W  count of completed instructions, wraps at 2^CNT_W

Behaviour:
- Reset is synchronous, clock is clk. Reset forces state FETCH and zeroes every output except inst_ready, which is 1. Reset mid-instruction drops all strobes at that edge; the instruction is discarded and not counted.
- Field decode, with F = inst[2*RA_W-1:0], H = inst[2*RA_W-1:RA_W], L = inst[RA_W-1:0]:
  - LD 0000, ST 0001, MI 0010: rd=0, rs=0, immediate = sext(F), alu_src=1.
  - Immediate ops SMI 1100, SBI 1101, ANI 1110, CMI 1111, ORI 1001, XRI 1011: rd=H, rs=0, immediate = sext(L), alu_src=1.
  - Register ops MR 0011, SUM 0100, SB 0101, ANR 0110, CM 0111, ORR 1000, XRR 1010: rd=H, rs=L, immediate=0, alu_src=0.
- opcode, rd, rs, immediate and alu_src are registered on the accepting edge and held until the next acceptance.
- FSM transitions:
  - FETCH: inst_ready=1. On inst_valid go to DECODE, otherwise stay.
  - DECODE: 1 cycle, all strobes 0. LD/ST go to MEM; all others go to EXEC.
  - EXEC: 1 cycle, alu_en=1. flag_we=1 for SUM, SB, CM, SMI, SBI, CMI. CM/CMI then go to FETCH and count as retired; all others go to WB.
  - MEM: mem_read (LD) or mem_write (ST) is held high. A wait counter clears on entry and increments each cycle.
    - On mem_ack: LD goes to WB; ST goes to FETCH and is retired.
    - If no ack after MEM_TIMEOUT cycles in MEM: strobe drops, mem_err pulses 1 cycle, go to FETCH, not retired.
    - mem_ack outside MEM is ignored.
  - WB: reg_write=1 for exactly 1 cycle, retired += 1, go to FETCH.
- Latency from the acceptance edge (cycle 0), counting the state active in each cycle:
  - Register/immediate ALU op: DECODE c1, EXEC c2, WB c3, inst_ready c4.
  - CM/CMI: inst_ready in c3.
  - LD with ack in first MEM cycle (c2): WB c3.
- Strobes are mutually exclusive; at most one of alu_en, mem_read, mem_write, reg_write is high in any cycle.
- Simultaneous mem_ack and timeout on the same cycle: ack wins, no mem_err.

Test Plan:
1. Reset, then inst=8'h4B valid at c0 -> opcode=4, rd=2, rs=3, alu_src=0; alu_en+flag_we c2; reg_write c3; inst_ready c4; retired=1.
2. inst=8'h0C (LD), mem_ack asserted in 3rd MEM cycle -> immediate=8'hFC, rd=0, mem_read high 3 cycles, reg_write next cycle, retired increments.
3. inst=8'hC6 (SMI) -> rd=1, immediate=8'hFE, alu_src=1, flag_we in EXEC, reg_write in WB.
4. inst=8'h15 (ST), mem_ack never asserted -> mem_write high exactly 16 cycles, mem_err 1-cycle pulse, back to FETCH, retired unchanged.
5. inst=8'h79 (CM) -> alu_en+flag_we c2, no reg_write, inst_ready c3; back-to-back inst_valid accepted c3.
6. reset asserted during MEM of LD -> next cycle all strobes 0, inst_ready=1, retired=0; subsequent 8'h4B completes normally.
